// File: rtl/team_08_gpio_pkg.sv
// Shared constants for the team_08 GPIO front end: register map, LA bus field
// positions and the pin-count ceiling.
package team_08_gpio_pkg;

  localparam int MAX_PINS = 64;

  localparam logic [7:0] ADDR_OVR_EN     = 8'd0;
  localparam logic [7:0] ADDR_OVR_VAL    = 8'd1;
  localparam logic [7:0] ADDR_OVR_OE     = 8'd2;
  localparam logic [7:0] ADDR_RISE_MASK  = 8'd3;
  localparam logic [7:0] ADDR_FALL_MASK  = 8'd4;
  localparam logic [7:0] ADDR_STATUS_CLR = 8'd5;

  localparam int LA_WDATA_LSB = 0;
  localparam int LA_ADDR_LSB  = 64;
  localparam int LA_STB_BIT   = 72;

endpackage

// File: rtl/team_08_gpio_pin_in.sv
// One GPIO input lane: synchroniser, optional debounce (TEAM_08_GPIO_DEBOUNCE_EN),
// and registered rise/fall pulses that follow pin_val transitions by one cycle.
module team_08_gpio_pin_in #(
  parameter int SYNC_STAGES = 2
`ifdef TEAM_08_GPIO_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 4
  , parameter int DEB_W      = $clog2(DEB_CYCLES + 1)
`endif
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic i_pin,
  output logic o_val,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_val;
  logic                   r_val_d;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync <= '0;
    end else if (!en) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

`ifdef TEAM_08_GPIO_DEBOUNCE_EN
  logic [DEB_W-1:0] r_cnt;

  // pin_val only follows s after it has differed for DEB_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
      r_val <= 1'b0;
    end else if (!en) begin
      r_cnt <= '0;
      r_val <= 1'b0;
    end else if (w_s == r_val) begin
      r_cnt <= '0;
    end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      r_val <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_val <= 1'b0;
    end else if (!en) begin
      r_val <= 1'b0;
    end else begin
      r_val <= w_s;
    end
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_val_d <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else if (!en) begin
      r_val_d <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_val_d <= r_val;
      r_rise  <= r_val & ~r_val_d;
      r_fall  <= ~r_val & r_val_d;
    end
  end

  assign o_val  = r_val;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/team_08_gpio_ctrl.sv
// GPIO front end: LA register port, pin override/drive registers, per-pin input
// lanes and sticky maskable interrupt. Debounce is built when TEAM_08_GPIO_DEBOUNCE_EN is defined.
module team_08_gpio_ctrl
  import team_08_gpio_pkg::*;
#(
  parameter int NUM_PINS    = 34,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1000,
  parameter int DEB_W       = $clog2(DEB_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic [127:0]        la_data_in,
  input  logic [127:0]        la_oenb,
  output logic [127:0]        la_data_out,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oeb,
  input  logic [NUM_PINS-1:0] core_out,
  input  logic [NUM_PINS-1:0] core_oe,
  output logic [NUM_PINS-1:0] pin_val,
  output logic [NUM_PINS-1:0] rise,
  output logic [NUM_PINS-1:0] fall,
  output logic                irq
);

  if (NUM_PINS < 1 || NUM_PINS > MAX_PINS || SYNC_STAGES < 2 || DEB_CYCLES < 1 ||
      DEB_W != $clog2(DEB_CYCLES + 1)) begin : g_param_err
    $error("team_08_gpio_ctrl: illegal parameter combination");
  end

  logic                r_stb;
  logic                r_stb_d;
  logic [7:0]          r_addr;
  logic [NUM_PINS-1:0] r_wdata;
  logic                w_wr;

  logic [NUM_PINS-1:0] r_ovr_en, r_ovr_val, r_ovr_oe, r_rise_mask, r_fall_mask;
  logic [NUM_PINS-1:0] r_gpio_out, r_gpio_oeb, r_irq_status;
  logic                r_irq;
  logic [NUM_PINS-1:0] w_pin_val, w_rise, w_fall, w_set, w_clr;
  logic [63:0]         w_pin64, w_status64;
  logic                w_unused_la;

  assign w_unused_la = ^{la_data_in, la_oenb};

  // Address and data are captured alongside the strobe so the write uses the edge-cycle values
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_stb   <= 1'b0;
      r_stb_d <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_stb   <= la_data_in[LA_STB_BIT] & ~la_oenb[LA_STB_BIT];
      r_stb_d <= r_stb;
      r_addr  <= la_data_in[LA_ADDR_LSB +: 8];
      r_wdata <= la_data_in[LA_WDATA_LSB +: NUM_PINS];
    end
  end

  assign w_wr = r_stb & ~r_stb_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ovr_en    <= '0;
      r_ovr_val   <= '0;
      r_ovr_oe    <= '0;
      r_rise_mask <= '0;
      r_fall_mask <= '0;
    end else if (w_wr) begin
      case (r_addr)
        ADDR_OVR_EN:    r_ovr_en    <= r_wdata;
        ADDR_OVR_VAL:   r_ovr_val   <= r_wdata;
        ADDR_OVR_OE:    r_ovr_oe    <= r_wdata;
        ADDR_RISE_MASK: r_rise_mask <= r_wdata;
        ADDR_FALL_MASK: r_fall_mask <= r_wdata;
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_gpio_out <= '0;
      r_gpio_oeb <= '1;
    end else if (!en) begin
      r_gpio_out <= '0;
      r_gpio_oeb <= '1;
    end else begin
      r_gpio_out <= (r_ovr_en & r_ovr_val) | (~r_ovr_en & core_out);
      r_gpio_oeb <= ~((r_ovr_en & r_ovr_oe) | (~r_ovr_en & core_oe));
    end
  end

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    team_08_gpio_pin_in #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef TEAM_08_GPIO_DEBOUNCE_EN
      , .DEB_CYCLES(DEB_CYCLES)
      , .DEB_W(DEB_W)
`endif
    ) u_pin (
      .clk   (clk),
      .nrst  (nrst),
      .en    (en),
      .i_pin (gpio_in[g]),
      .o_val (w_pin_val[g]),
      .o_rise(w_rise[g]),
      .o_fall(w_fall[g])
    );
  end

  assign w_set = (w_rise & r_rise_mask) | (w_fall & r_fall_mask);
  assign w_clr = (w_wr && r_addr == ADDR_STATUS_CLR) ? r_wdata : '0;

  // Set is OR-ed in after the clear so a same-cycle event is never lost
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_irq_status <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_irq_status <= en ? ((r_irq_status & ~w_clr) | w_set) : '0;
      r_irq        <= |r_irq_status;
    end
  end

  always_comb begin
    w_pin64                  = '0;
    w_status64               = '0;
    w_pin64[NUM_PINS-1:0]    = w_pin_val;
    w_status64[NUM_PINS-1:0] = r_irq_status;
  end

  assign la_data_out = {w_status64, w_pin64};
  assign gpio_out    = r_gpio_out;
  assign gpio_oeb    = r_gpio_oeb;
  assign pin_val     = w_pin_val;
  assign rise        = w_rise;
  assign fall        = w_fall;
  assign irq         = r_irq;

endmodule

// File: tb/tb_team_08_gpio_ctrl.sv
// Directed bench for team_08_gpio_ctrl with 8 pins, 2 sync stages, 4 debounce cycles;
// expectations adapt to whether TEAM_08_GPIO_DEBOUNCE_EN is defined.
module tb_team_08_gpio_ctrl;

  localparam int NP = 8;
`ifdef TEAM_08_GPIO_DEBOUNCE_EN
  localparam int   LAT        = 6;
  localparam logic GLITCH_EXP = 1'b0;
`else
  localparam int   LAT        = 3;
  localparam logic GLITCH_EXP = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          nrst;
  logic          en;
  logic [127:0]  la_data_in;
  logic [127:0]  la_oenb;
  logic [127:0]  la_data_out;
  logic [NP-1:0] gpio_in, gpio_out, gpio_oeb, core_out, core_oe;
  logic [NP-1:0] pin_val, rise, fall;
  logic          irq;

  int n_total = 0;
  int n_bad   = 0;

  team_08_gpio_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_data_out),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oeb   (gpio_oeb),
    .core_out   (core_out),
    .core_oe    (core_oe),
    .pin_val    (pin_val),
    .rise       (rise),
    .fall       (fall),
    .irq        (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one LA register write; blocked=1 drives la_oenb[72] high
  task automatic la_write(input logic [7:0] addr, input logic [63:0] data, input logic blocked);
    la_data_in[63:0]  = data;
    la_data_in[71:64] = addr;
    la_data_in[72]    = 1'b1;
    la_oenb[72]       = blocked;
    step(1);
    la_data_in[72]    = 1'b0;
    la_oenb[72]       = 1'b0;
    step(1);
  endtask

  typedef struct {
    logic          en;
    logic [NP-1:0] core_out;
    logic [NP-1:0] core_oe;
    logic [NP-1:0] exp_out;
    logic [NP-1:0] exp_oeb;
  } vec_t;

  vec_t          vecs[5];
  logic [15:0]   exp_q[$];
  logic [15:0]   exp_v;
  logic          pv_seen, rise_seen, irq_seen;

  initial begin
    vecs[0] = '{1'b1, 8'h3C, 8'h0F, 8'h3C, 8'hF0};
    vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    vecs[2] = '{1'b0, 8'h55, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 8'hA5, 8'h5A, 8'hA5, 8'hA5};

    nrst       = 1'b0;
    en         = 1'b0;
    la_data_in = '0;
    la_oenb    = '0;
    gpio_in    = '0;
    core_out   = 8'hA5;
    core_oe    = '1;
    step(2);
    check("rst_oeb", gpio_oeb, 8'hFF);
    check("rst_out", gpio_out, 8'h00);
    check("rst_pin_val", pin_val, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_la_out", la_data_out, 128'h0);

    nrst = 1'b1;
    step(2);
    check("en0_oeb", gpio_oeb, 8'hFF);
    check("en0_out", gpio_out, 8'h00);
    en = 1'b1;
    step(1);
    check("en1_oeb", gpio_oeb, 8'h00);
    check("en1_out", gpio_out, 8'hA5);

    // output path table
    for (int i = 0; i < 5; i++) begin
      en       = vecs[i].en;
      core_out = vecs[i].core_out;
      core_oe  = vecs[i].core_oe;
      exp_q.push_back({vecs[i].exp_out, vecs[i].exp_oeb});
      step(1);
      exp_v = exp_q.pop_front();
      check($sformatf("vec%0d_out", i), gpio_out, exp_v[15:8]);
      check($sformatf("vec%0d_oeb", i), gpio_oeb, exp_v[7:0]);
    end

    // LA override of pin 0
    core_out = 8'h00;
    core_oe  = 8'h00;
    la_write(8'd0, 64'h1, 1'b0);
    la_write(8'd2, 64'h1, 1'b0);
    la_write(8'd1, 64'h1, 1'b0);
    step(1);
    check("ovr_out", gpio_out, 8'h01);
    check("ovr_oeb", gpio_oeb, 8'hFE);
    core_out = 8'hF0;
    core_oe  = 8'hF0;
    step(1);
    check("ovr_mix_out", gpio_out, 8'hF1);
    check("ovr_mix_oeb", gpio_oeb, 8'h0E);

    // strobe held high while data changes: only the first value lands
    la_data_in[63:0]  = 64'h0;
    la_data_in[71:64] = 8'd1;
    la_data_in[72]    = 1'b1;
    step(3);
    la_data_in[63:0]  = 64'h1;
    step(3);
    la_data_in[72]    = 1'b0;
    step(2);
    check("held_stb_out", gpio_out, 8'hF0);

    // rejected writes: blocked by la_oenb, and an unmapped address
    core_out = 8'h0F;
    core_oe  = 8'h00;
    la_write(8'd0, 64'hF0, 1'b0);
    la_write(8'd0, 64'hFF, 1'b1);
    la_write(8'd9, 64'hFF, 1'b0);
    step(1);
    check("reject_out", gpio_out, 8'h0F);
    check("reject_oeb", gpio_oeb, 8'hFF);
    la_write(8'd0, 64'h0, 1'b0);

    // stable rise on pin 3, no mask
    gpio_in[3] = 1'b1;
    step(LAT - 1);
    check("p3_before", pin_val, 8'h00);
    step(1);
    check("p3_after", pin_val, 8'h08);
    check("p3_rise_early", rise, 8'h00);
    step(1);
    check("p3_rise", rise, 8'h08);
    step(1);
    check("p3_rise_end", rise, 8'h00);
    check("p3_irq_unmasked", irq, 1'b0);
    check("p3_status_unmasked", la_data_out[127:64], 64'h0);

    // 3-cycle glitch on pin 5 with its rise unmasked
    la_write(8'd3, 64'h20, 1'b0);
    pv_seen = 1'b0;
    rise_seen = 1'b0;
    irq_seen = 1'b0;
    gpio_in[5] = 1'b1;
    step(3);
    gpio_in[5] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      pv_seen   = pv_seen | pin_val[5];
      rise_seen = rise_seen | rise[5];
      irq_seen  = irq_seen | irq;
    end
    check("glitch_pin_val", pv_seen, GLITCH_EXP);
    check("glitch_rise", rise_seen, GLITCH_EXP);
    check("glitch_irq", irq_seen, GLITCH_EXP);
    la_write(8'd5, 64'h20, 1'b0);
    step(1);
    check("glitch_irq_clr", irq, 1'b0);

    // masked rise on pin 3 and the irq latency
    la_write(8'd3, 64'h08, 1'b0);
    gpio_in[3] = 1'b0;
    step(LAT + 3);
    check("p3_fall_unmasked", la_data_out[127:64], 64'h0);
    gpio_in[3] = 1'b1;
    step(LAT + 1);
    check("p3b_rise", rise, 8'h08);
    step(1);
    check("p3b_status", la_data_out[127:64], 64'h8);
    check("p3b_irq_lag", irq, 1'b0);
    step(1);
    check("p3b_irq", irq, 1'b1);
    check("p3b_la67", la_data_out[67], 1'b1);
    la_write(8'd5, 64'h8, 1'b0);
    check("clr1_status", la_data_out[127:64], 64'h0);
    step(1);
    check("clr1_irq", irq, 1'b0);

    // clear landing on the same edge as a new rise: set wins
    gpio_in[3] = 1'b0;
    step(LAT + 3);
    gpio_in[3] = 1'b1;
    step(LAT);
    la_write(8'd5, 64'h8, 1'b0);
    check("collide_status", la_data_out[127:64], 64'h8);
    step(1);
    check("collide_irq", irq, 1'b1);
    la_write(8'd5, 64'h8, 1'b0);
    check("clr2_status", la_data_out[127:64], 64'h0);
    step(1);
    check("clr2_irq", irq, 1'b0);

    // en dropped while pin 6 is qualifying
    gpio_in[6] = 1'b1;
    step(4);
    en = 1'b0;
    step(1);
    check("en_low_pin_val", pin_val, 8'h00);
    check("en_low_out", gpio_out, 8'h00);
    check("en_low_oeb", gpio_oeb, 8'hFF);
    en = 1'b1;
    step(LAT - 1);
    check("requal_before", pin_val, 8'h00);
    step(1);
    check("requal_after", pin_val, 8'h48);

    // asynchronous reset mid-cycle
    step(2);
    #3;
    nrst = 1'b0;
    #1;
    check("async_pin_val", pin_val, 8'h00);
    check("async_out", gpio_out, 8'h00);
    check("async_oeb", gpio_oeb, 8'hFF);
    check("async_la_out", la_data_out, 128'h0);
    check("async_irq", irq, 1'b0);
    step(2);
    nrst = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
